// File: rtl/fp2fx_pkg.sv
// rtl/fp2fx_pkg.sv - FP16 field constants and shared types for the FP16 -> fixed-point stream
// Purpose: FP16 field widths, exponent bias, special exponent code, the decoded FP16
//          struct and the rounding-mode enum shared by the interface, lane and top.
// Ports:   none (package).
package fp2fx_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp16_t;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

endpackage

// File: rtl/fp16_to_fixed_stream_if.sv
// rtl/fp16_to_fixed_stream_if.sv - valid/ready bus for the FP16 -> fixed-point stream
// Purpose: groups the input beat (in_valid/in_ready/in_data/rnd_mode) and the output
//          beat (out_valid/out_ready/out_data/out_ovf/out_nan/out_inexact).
// Modports: master = upstream producer plus downstream consumer, slave = converter.
interface fp16_to_fixed_stream_if
    import fp2fx_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OUT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [16*LANES-1:0]    in_data;
    rnd_mode_e              rnd_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W*LANES-1:0] out_data;
    logic [LANES-1:0]       out_ovf;
    logic [LANES-1:0]       out_nan;
    logic [LANES-1:0]       out_inexact;

    modport master (
        output in_valid, in_data, rnd_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
    );

    modport slave (
        input  in_valid, in_data, rnd_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
    );
endinterface

// File: rtl/fp2fx_lane.sv
// rtl/fp2fx_lane.sv - one lane of the FP16 -> fixed-point pipeline (S1 decode/align, S2 round/saturate)
// Purpose: S1 decodes the FP16 value, aligns the significand to FRAC_W fraction bits and
//          keeps guard/sticky; S2 rounds the magnitude, applies the sign, clamps and flags.
// Ports:   clk, rst (async, active high); en1/en2 load S1/S2; fp, rnd = lane input;
//          data, ovf, nan, inexact = registered S2 result.
module fp2fx_lane
    import fp2fx_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en1,
    input  logic             en2,
    input  fp16_t            fp,
    input  rnd_mode_e        rnd,
    output logic [OUT_W-1:0] data,
    output logic             ovf,
    output logic             nan,
    output logic             inexact
);
    // Largest right shift kept exactly; anything further only contributes sticky.
    localparam int RS_MAX = 24;
    localparam int RW     = MAN_W + 1 + RS_MAX + 1;

    localparam logic [OUT_W+1:0] POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W+1:0] NEG_LIM = {2'b00, 1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

    // S1 combinational decode/align
    logic [EXP_W-1:0] e_eff;
    logic [MAN_W:0]   m;
    logic             is_special;
    int               sh;
    logic [RW-1:0]    tmp_r;
    logic [63:0]      val;
    logic             c_g, c_s, c_big, c_nan;
    logic [OUT_W:0]   c_mag;

    always_comb begin
        // Denormals use exponent 1 with no implicit bit, so they convert exactly.
        e_eff      = (fp.exp == '0) ? EXP_W'(1) : fp.exp;
        m          = {fp.exp != '0, fp.mant};
        is_special = (fp.exp == EXP_INF);
        sh         = int'(e_eff) - BIAS - MAN_W + FRAC_W;
        tmp_r      = '0;
        val        = '0;
        c_g        = 1'b0;
        c_s        = 1'b0;
        if (sh >= 0) begin
            val = 64'(m) << sh;
        end else if (-sh > RS_MAX) begin
            c_s = |m;
        end else begin
            tmp_r = {m, (RS_MAX+1)'(0)} >> (-sh);
            val   = 64'(tmp_r[RW-1 -: MAN_W+1]);
            c_g   = tmp_r[RS_MAX];
            c_s   = |tmp_r[RS_MAX-1:0];
        end
        // Anything above bit OUT_W cannot fit even before rounding.
        c_big = |(val >> (OUT_W+1));
        c_mag = val[OUT_W:0];
        c_nan = 1'b0;
        if (is_special) begin
            c_g   = 1'b0;
            c_s   = 1'b0;
            c_mag = '0;
            c_nan = (fp.mant != '0);
            c_big = (fp.mant == '0);
        end
    end

    logic           s1_sign, s1_nan, s1_big, s1_g, s1_s;
    logic [OUT_W:0] s1_mag;
    rnd_mode_e      s1_rnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign <= 1'b0;
            s1_nan  <= 1'b0;
            s1_big  <= 1'b0;
            s1_g    <= 1'b0;
            s1_s    <= 1'b0;
            s1_mag  <= '0;
            s1_rnd  <= RND_TRUNC;
        end else if (en1) begin
            s1_sign <= fp.sign;
            s1_nan  <= c_nan;
            s1_big  <= c_big;
            s1_g    <= c_g;
            s1_s    <= c_s;
            s1_mag  <= c_mag;
            s1_rnd  <= rnd;
        end
    end

    // S2 combinational round/sign/saturate; rounding acts on the magnitude,
    // so truncation is toward zero for both signs.
    logic             inc;
    logic [OUT_W+1:0] mag_r;
    logic             c_ovf;
    logic [OUT_W-1:0] c_res;

    always_comb begin
        inc   = (s1_rnd == RND_RNE) & s1_g & (s1_s | s1_mag[0]);
        mag_r = {1'b0, s1_mag} + (OUT_W+2)'(inc);
        c_ovf = s1_big | (s1_sign ? (mag_r > NEG_LIM) : (mag_r > POS_LIM));
        if (c_ovf) begin
            c_res = s1_sign ? NEG_SAT : POS_SAT;
        end else if (s1_sign) begin
            c_res = -mag_r[OUT_W-1:0];
        end else begin
            c_res = mag_r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            ovf     <= 1'b0;
            nan     <= 1'b0;
            inexact <= 1'b0;
        end else if (en2) begin
            data    <= c_res;
            ovf     <= c_ovf;
            nan     <= s1_nan;
            inexact <= s1_g | s1_s;
        end
    end

endmodule

// File: rtl/fp16_to_fixed_stream.sv
// rtl/fp16_to_fixed_stream.sv - pipelined multi-lane FP16 -> signed fixed-point converter
// Purpose: two-stage valid/ready pipeline around LANES fp2fx_lane instances.
// Ports:   clk, rst (async, active high); bus = fp16_to_fixed_stream_if.slave;
//          sat_cnt [31:0] (only with FP2FX_SAT_CNT_EN) = saturating count of lanes
//          flagged ovf on output transfers.
// Config:  FP2FX_SAT_CNT_EN adds the sat_cnt port and counter.
module fp16_to_fixed_stream
    import fp2fx_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fp16_to_fixed_stream_if.slave   bus
`ifdef FP2FX_SAT_CNT_EN
    ,
    output logic [31:0]             sat_cnt
`endif
);
    logic rdy_en;
    logic s1_v, s2_v;
    logic adv1, adv2;
    logic in_fire, ld2;

    logic [OUT_W*LANES-1:0] data_w;
    logic [LANES-1:0]       ovf_w, nan_w, inex_w;

    assign adv2         = !s2_v | bus.out_ready;
    assign adv1         = !s1_v | adv2;
    // rdy_en holds in_ready low until the first edge after reset release.
    assign bus.in_ready = rdy_en & adv1;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign ld2          = adv2 & s1_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (adv1) s1_v <= in_fire;
            if (adv2) s2_v <= s1_v;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp2fx_lane #(
            .OUT_W  (OUT_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en1     (in_fire),
            .en2     (ld2),
            .fp      (fp16_t'(bus.in_data[16*i +: 16])),
            .rnd     (bus.rnd_mode),
            .data    (data_w[OUT_W*i +: OUT_W]),
            .ovf     (ovf_w[i]),
            .nan     (nan_w[i]),
            .inexact (inex_w[i])
        );
    end

    assign bus.out_valid   = s2_v;
    assign bus.out_data    = data_w;
    assign bus.out_ovf     = ovf_w;
    assign bus.out_nan     = nan_w;
    assign bus.out_inexact = inex_w;

`ifdef FP2FX_SAT_CNT_EN
    logic [32:0] cnt_sum;
    assign cnt_sum = {1'b0, sat_cnt} + 33'($countones(ovf_w));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            sat_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end
`else
    // Saturation counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fp16_to_fixed_stream.sv
// tb/tb_fp16_to_fixed_stream.sv - scoreboard bench for fp16_to_fixed_stream (LANES=4, OUT_W=16, FRAC_W=8)
module tb_fp16_to_fixed_stream;
    import fp2fx_pkg::*;

    typedef struct {
        logic [63:0] din;
        logic        rnd;
        logic [63:0] dout;
        logic [3:0]  ovf;
        logic [3:0]  nan;
        logic [3:0]  inex;
    } vec_t;

    typedef struct {
        logic [63:0] dout;
        logic [3:0]  ovf;
        logic [3:0]  nan;
        logic [3:0]  inex;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   failed   = 0;
    logic rand_mode  = 1'b0;
    logic ready_fixed = 1'b1;
    exp_t sb[$];
    vec_t vecs[8];

    fp16_to_fixed_stream_if #(.LANES(4), .OUT_W(16)) bus();

`ifdef FP2FX_SAT_CNT_EN
    logic [31:0] sat_cnt;
`endif

    fp16_to_fixed_stream #(.LANES(4), .OUT_W(16), .FRAC_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef FP2FX_SAT_CNT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [63:0] di, input logic r, input logic [63:0] dout,
                                input logic [3:0] o, input logic [3:0] n, input logic [3:0] x);
        vec_t v;
        v.din = di; v.rnd = r; v.dout = dout; v.ovf = o; v.nan = n; v.inex = x;
        return v;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Downstream ready: fixed level or random toggle, updated away from both edges.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Output monitor: every valid cycle must show the oldest outstanding beat.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL out_unexpected: got data %h with empty scoreboard", bus.out_data);
            end else begin
                check(bus.out_ready ? "out_beat" : "out_hold",
                      {bus.out_data}, sb[0].dout);
                check("out_flags",
                      {52'b0, bus.out_ovf, bus.out_nan, bus.out_inexact},
                      {52'b0, sb[0].ovf, sb[0].nan, sb[0].inex});
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v.din;
        bus.rnd_mode = rnd_mode_e'(v.rnd);
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            compared++;
            failed++;
            $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        e.dout = v.dout; e.ovf = v.ovf; e.nan = v.nan; e.inex = v.inex;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            n++;
            @(posedge clk);
        end
        compared++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk({16'h0000,16'h3400,16'hBC00,16'h3C00}, 1'b1,
                     {16'h0000,16'h0040,16'hFF00,16'h0100}, 4'b0000, 4'b0000, 4'b0000);
        vecs[1] = mk({16'h57FF,16'h7E00,16'hFC00,16'h7C00}, 1'b1,
                     {16'h7FF0,16'h0000,16'h8000,16'h7FFF}, 4'b0011, 4'b0100, 4'b0000);
        vecs[2] = mk({16'hBC06,16'h03FF,16'h3C02,16'h3C06}, 1'b1,
                     {16'hFEFE,16'h0000,16'h0100,16'h0102}, 4'b0000, 4'b0000, 4'b1111);
        vecs[3] = mk({16'hBC06,16'h03FF,16'h3C02,16'h3C06}, 1'b0,
                     {16'hFEFF,16'h0000,16'h0100,16'h0101}, 4'b0000, 4'b0000, 4'b1111);
        vecs[4] = mk({16'h8000,16'hD800,16'h5800,16'h5BFF}, 1'b1,
                     {16'h0000,16'h8000,16'h7FFF,16'h7FFF}, 4'b0011, 4'b0000, 4'b0000);
        vecs[5] = mk({16'h3C01,16'h0001,16'h3A00,16'h3E00}, 1'b1,
                     {16'h0100,16'h0000,16'h00C0,16'h0180}, 4'b0000, 4'b0000, 4'b1100);
        vecs[6] = mk({16'h3800,16'h3C07,16'h3C0E,16'h3C0A}, 1'b1,
                     {16'h0080,16'h0102,16'h0104,16'h0102}, 4'b0000, 4'b0000, 4'b0111);
        vecs[7] = mk({16'h0000,16'h7BFF,16'hFFFF,16'hD7FF}, 1'b0,
                     {16'h0000,16'h7FFF,16'h0000,16'h8010}, 4'b0100, 4'b0010, 4'b0000);

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rnd_mode = RND_TRUNC;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus.out_data[47:0], 4'b0, bus.out_ovf, bus.out_nan, bus.out_inexact},
              64'h0);
        check("reset_data_hi", {48'b0, bus.out_data[63:48]}, 64'h0);
        check("reset_valid_ready", {62'b0, bus.out_valid, bus.in_ready}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_release_edge", {63'b0, bus.in_ready}, 64'h0);
        @(negedge clk);
        check("in_ready_after_release", {63'b0, bus.in_ready}, 64'h1);
        @(posedge clk);
        #1;

        // Latency: accept on edge T, out_valid visible after edge T+1.
        send(vecs[0]);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1", {63'b0, bus.out_valid}, 64'h0);
        @(negedge clk);
        check("latency_cycle2", {63'b0, bus.out_valid}, 64'h1);
        drain();

        // Table vectors back to back at full throughput.
        for (int i = 0; i < 8; i++) send(vecs[i]);
        bus.in_valid = 1'b0;
        drain();

        // 20 beats with random downstream stalls; rounding mode varies per beat.
        rand_mode = 1'b1;
        for (int j = 0; j < 20; j++) send(vecs[(j * 3) % 8]);
        bus.in_valid = 1'b0;
        drain();
        rand_mode = 1'b0;

        // Reset with both stages full and output stalled.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(vecs[1]);
        send(vecs[3]);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall_in_ready", {63'b0, bus.in_ready}, 64'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_out_valid", {63'b0, bus.out_valid}, 64'h0);
        check("midreset_out_data", bus.out_data, 64'h0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        ready_fixed = 1'b1;
        @(posedge clk);
        #1;
        send(vecs[2]);
        bus.in_valid = 1'b0;
        drain();

`ifdef FP2FX_SAT_CNT_EN
        begin
            vec_t vs;
            vs = mk({4{16'h7C00}}, 1'b1, {4{16'h7FFF}}, 4'b1111, 4'b0000, 4'b0000);
            for (int k = 0; k < 3; k++) send(vs);
            bus.in_valid = 1'b0;
            drain();
            @(negedge clk);
            check("sat_cnt", {32'b0, sat_cnt}, 64'd12);
        end
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
